// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port unified-memory arbiter.
// The state codes are fixed so that existing debug tooling keeps decoding them.
package mem_arb_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    localparam logic P_FETCH = 1'b0;
    localparam logic P_DATA  = 1'b1;

endpackage

// File: rtl/m_rr_pick2.sv
// Combinational two-way round-robin picker.
// On a tie, the port that did not win last time is chosen.
module m_rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       pick
);

    assign valid = |req;
    assign pick  = (&req) ? ~last : (req[P_DATA] ? P_DATA : P_FETCH);

endmodule

// File: rtl/m_mem_arb2.sv
// Fetch/load-store arbiter that sequences one synchronous-read word memory.
// Each transaction runs IDLE -> ACC -> RSP, giving one access every three cycles.
module m_mem_arb2
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_req0,
    input  logic              w_req1,
    input  logic [ADDR_W-1:0] w_addr0,
    input  logic [ADDR_W-1:0] w_addr1,
    input  logic              w_we0,
    input  logic              w_we1,
    input  logic [DATA_W-1:0] w_wdata0,
    input  logic [DATA_W-1:0] w_wdata1,
    output logic              r_gnt0,
    output logic              r_gnt1,
    output logic              r_ack0,
    output logic              r_ack1,
    output logic [DATA_W-1:0] r_rdata,
    output logic [ADDR_W-1:0] w_maddr,
    output logic              w_mwe,
    output logic [DATA_W-1:0] w_mdin,
    input  logic [DATA_W-1:0] w_mdout
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_own;
    logic              r_last;

    logic              pk_valid;
    logic              pk_pick;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;

    m_rr_pick2 u_pick (
        .req   ({w_req1, w_req0}),
        .last  (r_last),
        .valid (pk_valid),
        .pick  (pk_pick)
    );

    assign sel_addr  = (pk_pick == P_DATA) ? w_addr1  : w_addr0;
    assign sel_we    = (pk_pick == P_DATA) ? w_we1    : w_we0;
    assign sel_wdata = (pk_pick == P_DATA) ? w_wdata1 : w_wdata0;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_own   <= P_FETCH;
            r_last  <= P_DATA;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pk_valid) begin
                        r_state <= S_ACC;
                        r_addr  <= sel_addr;
                        r_we    <= sel_we;
                        r_wdata <= sel_wdata;
                        r_own   <= pk_pick;
                        r_last  <= pk_pick;
                        r_gnt0  <= (pk_pick == P_FETCH);
                        r_gnt1  <= (pk_pick == P_DATA);
                    end
                end
                S_ACC: r_state <= S_RSP;
                // Memory output is valid here, one cycle after the address was sampled.
                S_RSP: begin
                    r_state <= S_IDLE;
                    r_rdata <= w_mdout;
                    r_ack0  <= (r_own == P_FETCH);
                    r_ack1  <= (r_own == P_DATA);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_maddr = r_addr;
    assign w_mdin  = r_wdata;
    // Decoded from the state register so an async reset kills a pending write at once.
    assign w_mwe   = (r_state == S_ACC) & r_we;

endmodule

// File: tb/tb_m_mem_arb2.sv
// Directed bench for m_mem_arb2 with a read-before-write memory and a transaction-level model.
module tb_m_mem_arb2;

    logic        w_clk = 1'b0;
    logic        w_rst;
    logic        w_req0, w_req1, w_we0, w_we1;
    logic [10:0] w_addr0, w_addr1;
    logic [31:0] w_wdata0, w_wdata1;
    logic        r_gnt0, r_gnt1, r_ack0, r_ack1;
    logic [31:0] r_rdata;
    logic [10:0] w_maddr;
    logic        w_mwe;
    logic [31:0] w_mdin;
    logic [31:0] w_mdout;

    logic        pl_en;
    logic [3:0]  pl_addr;
    logic [31:0] pl_data;

    int nvec = 0;
    int nerr = 0;
    int mwe_cnt = 0;

    always #5 w_clk = ~w_clk;

    m_mem_arb2 dut (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .w_req0   (w_req0),
        .w_req1   (w_req1),
        .w_addr0  (w_addr0),
        .w_addr1  (w_addr1),
        .w_we0    (w_we0),
        .w_we1    (w_we1),
        .w_wdata0 (w_wdata0),
        .w_wdata1 (w_wdata1),
        .r_gnt0   (r_gnt0),
        .r_gnt1   (r_gnt1),
        .r_ack0   (r_ack0),
        .r_ack1   (r_ack1),
        .r_rdata  (r_rdata),
        .w_maddr  (w_maddr),
        .w_mwe    (w_mwe),
        .w_mdin   (w_mdin),
        .w_mdout  (w_mdout)
    );

    // Synchronous-read, read-before-write memory (16 words are enough here)
    logic [31:0] mem [0:15];
    always @(posedge w_clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (w_mwe) mem[w_maddr[3:0]] <= w_mdin;
        w_mdout <= mem[w_maddr[3:0]];
    end

    // Transaction-level model: one access at a time, grant 1, commit at end of grant,
    // ack 3 cycles after the sampling edge, next sample 3 edges later.
    logic [31:0] shadow [0:15];
    int          cyc = 0;
    int          g_cyc = -10;
    int          a_cyc = -10;
    int          next_free = 0;
    bit          own = 1'b0;
    bit          last = 1'b1;
    bit          t_we = 1'b0;
    logic [10:0] t_addr = '0;
    logic [31:0] t_wdata = '0;
    logic [31:0] t_rd = '0;
    logic [31:0] m_rdata = '0;

    always @(posedge w_clk) begin
        if (pl_en) shadow[pl_addr] = pl_data;
        if (w_rst) begin
            g_cyc = -10; a_cyc = -10; next_free = 0; m_rdata = '0; last = 1'b1;
        end else begin
            if (cyc == g_cyc) begin
                t_rd = shadow[t_addr[3:0]];
                if (t_we) shadow[t_addr[3:0]] = t_wdata;
            end
            if (cyc == g_cyc + 1) m_rdata = t_rd;
            if (cyc >= next_free && (w_req0 || w_req1)) begin
                own       = (w_req0 && w_req1) ? ~last : w_req1;
                last      = own;
                g_cyc     = cyc + 1;
                a_cyc     = cyc + 3;
                next_free = cyc + 3;
                t_addr    = own ? w_addr1  : w_addr0;
                t_we      = own ? w_we1    : w_we0;
                t_wdata   = own ? w_wdata1 : w_wdata0;
            end
        end
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge w_clk) begin
        mwe_cnt += int'(w_mwe);
        if (!w_rst) begin
            chk("m_gnt0",  r_gnt0,  32'((cyc == g_cyc) && !own));
            chk("m_gnt1",  r_gnt1,  32'((cyc == g_cyc) && own));
            chk("m_ack0",  r_ack0,  32'((cyc == a_cyc) && !own));
            chk("m_ack1",  r_ack1,  32'((cyc == a_cyc) && own));
            chk("m_rdata", r_rdata, m_rdata);
            chk("m_mwe",   w_mwe,   32'((cyc == g_cyc) && t_we));
            if (cyc == g_cyc) chk("m_maddr", 32'(w_maddr), 32'(t_addr));
            if (cyc == g_cyc && t_we) chk("m_mdin", w_mdin, t_wdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gown[$];
        int gcy[$];
        int mwe0;
        w_rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        w_req0 = 0; w_req1 = 0; w_we0 = 0; w_we1 = 0;
        w_addr0 = '0; w_addr1 = '0; w_wdata0 = '0; w_wdata1 = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge w_clk);
            pl_en = 1'b1; pl_addr = 4'(i);
            pl_data = (i == 5) ? 32'h1234_5678 : 32'h0;
        end
        @(negedge w_clk); pl_en = 1'b0;
        @(negedge w_clk);
        chk("rst_gnt0", r_gnt0, 0);   chk("rst_gnt1", r_gnt1, 0);
        chk("rst_ack0", r_ack0, 0);   chk("rst_ack1", r_ack1, 0);
        chk("rst_rdata", r_rdata, 0); chk("rst_mwe", w_mwe, 0);
        chk("rst_maddr", 32'(w_maddr), 0); chk("rst_mdin", w_mdin, 0);
        w_rst = 1'b0;

        // single read of addr 5
        w_req0 = 1; w_addr0 = 11'd5;
        @(negedge w_clk); chk("t1_gnt0", r_gnt0, 1); chk("t1_gnt1", r_gnt1, 0); w_req0 = 0;
        @(negedge w_clk);
        @(negedge w_clk);
        chk("t1_ack0", r_ack0, 1); chk("t1_ack1", r_ack1, 0);
        chk("t1_rdata", r_rdata, 32'h1234_5678);

        // port 1 writes addr 7, then reads it back
        mwe0 = mwe_cnt;
        w_req1 = 1; w_we1 = 1; w_addr1 = 11'd7; w_wdata1 = 32'hDEAD_BEEF;
        @(negedge w_clk); w_we1 = 0;
        @(negedge w_clk);
        @(negedge w_clk); chk("t2_ack_w", r_ack1, 1); chk("t2_rdata_w", r_rdata, 32'h0);
        @(negedge w_clk); chk("t2_gnt_r", r_gnt1, 1); w_req1 = 0;
        @(negedge w_clk);
        @(negedge w_clk); chk("t2_ack_r", r_ack1, 1); chk("t2_rdata_r", r_rdata, 32'hDEAD_BEEF);
        chk("t2_mwe_cycles", 32'(mwe_cnt - mwe0), 1);

        // tie fairness from reset
        @(negedge w_clk); w_rst = 1;
        @(negedge w_clk); w_rst = 0;
        w_req0 = 1; w_req1 = 1; w_addr0 = 11'd1; w_addr1 = 11'd2;
        for (int i = 0; i < 12; i++) begin
            @(negedge w_clk);
            if (r_gnt0) begin gown.push_back(0); gcy.push_back(i); end
            if (r_gnt1) begin gown.push_back(1); gcy.push_back(i); end
        end
        w_req0 = 0; w_req1 = 0;
        chk("t3_ngrants", 32'(gown.size()), 4);
        for (int j = 0; j < gown.size() && j < 4; j++) begin
            chk("t3_owner", 32'(gown[j]), 32'(j % 2));
            chk("t3_cycle", 32'(gcy[j]), 32'(3 * j));
        end
        repeat (2) @(negedge w_clk);

        // single requester, back-to-back
        gown.delete(); gcy.delete();
        w_req1 = 1; w_addr1 = 11'd2;
        for (int i = 0; i < 9; i++) begin
            @(negedge w_clk);
            if (r_gnt0) begin gown.push_back(0); gcy.push_back(i); end
            if (r_gnt1) begin gown.push_back(1); gcy.push_back(i); end
        end
        w_req1 = 0;
        chk("t4_ngrants", 32'(gown.size()), 3);
        for (int j = 0; j < gown.size() && j < 3; j++) begin
            chk("t4_owner", 32'(gown[j]), 1);
            chk("t4_cycle", 32'(gcy[j]), 32'(3 * j));
        end
        repeat (2) @(negedge w_clk);

        // reset during the write access cycle
        w_req1 = 1; w_we1 = 1; w_addr1 = 11'd3; w_wdata1 = 32'hFFFF_FFFF;
        @(negedge w_clk); chk("t5_mwe_pre", w_mwe, 1);
        w_req1 = 0; w_we1 = 0;
        #1 w_rst = 1;
        #1;
        chk("t5_mwe", w_mwe, 0);     chk("t5_gnt1", r_gnt1, 0);
        chk("t5_ack1", r_ack1, 0);   chk("t5_rdata", r_rdata, 0);
        chk("t5_maddr", 32'(w_maddr), 0);
        @(negedge w_clk); chk("t5_mem3", mem[3], 32'h0);
        w_rst = 0;
        w_req0 = 1; w_req1 = 1; w_addr0 = 11'd11; w_addr1 = 11'd12;
        @(negedge w_clk); chk("t5_tie_gnt0", r_gnt0, 1); chk("t5_tie_gnt1", r_gnt1, 0);
        w_req0 = 0; w_req1 = 0;
        @(negedge w_clk);
        @(negedge w_clk); chk("t5_ack0", r_ack0, 1); chk("t5_ack1", r_ack1, 0);

        // address changes after grant; held request becomes a new transaction
        w_req0 = 1; w_addr0 = 11'd5;
        @(negedge w_clk); chk("t6_gnt0_a", r_gnt0, 1);
        @(negedge w_clk); w_addr0 = 11'd9;
        @(negedge w_clk); chk("t6_ack0_a", r_ack0, 1); chk("t6_rdata_a", r_rdata, 32'h1234_5678);
        @(negedge w_clk); chk("t6_gnt0_b", r_gnt0, 1); chk("t6_maddr_b", 32'(w_maddr), 9);
        w_req0 = 0;
        @(negedge w_clk);
        @(negedge w_clk); chk("t6_ack0_b", r_ack0, 1); chk("t6_rdata_b", r_rdata, 32'h0);

        repeat (3) @(negedge w_clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
